// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run controller: state codes, mode encodings
// and a small decode helper used by the top level.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_BRK  = 2'd3
    } run_state_t;

    localparam logic MODE_AUTO = 1'b0;
    localparam logic MODE_STEP = 1'b1;

    function automatic logic is_halted(input run_state_t s);
        return (s == ST_HALT) || (s == ST_BRK);
    endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector for a pulsed board button: a sample stage plus a
// history stage, so a held button yields a single one-cycle edge.
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic sampled;
    logic previous;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sampled  <= 1'b0;
            previous <= 1'b0;
        end else begin
            sampled  <= in;
            previous <= sampled;
        end
    end

    assign rise = sampled & ~previous;

endmodule

// File: rtl/run_ctrl.sv
// Single-clock execution scheduler for the processor: free-run at a
// programmable rate, single-step from a button, or stop on a breakpoint.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int DIV_W = 26,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] divisor,
    input  logic             mode,
    input  logic             run_btn,
    input  logic             step_btn,
    input  logic             brk_en,
    input  logic [7:0]       brk_addr,
    input  logic [7:0]       pc,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    run_state_t       cur_state;
    run_state_t       nxt_state;
    logic [DIV_W-1:0] tick_cnt;
    logic             run_rise;
    logic             step_rise;
    logic             tick;
    logic             brk_hit;
    logic             cpu_en_nxt;

    edge_rise u_run_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (run_btn),
        .rise (run_rise)
    );

    edge_rise u_step_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (step_btn),
        .rise (step_rise)
    );

    assign tick    = (cur_state == ST_RUN) && (tick_cnt == divisor);
    assign brk_hit = brk_en && (pc == brk_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= ST_HALT;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // A mode switch or run edge while running wins over a coincident tick.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_HALT: begin
                if (mode == MODE_AUTO && run_rise) begin
                    nxt_state = ST_RUN;
                end else if (mode == MODE_STEP && step_rise) begin
                    nxt_state = ST_STEP;
                end
            end
            ST_RUN: begin
                if (mode == MODE_STEP || run_rise) begin
                    nxt_state = ST_HALT;
                end else if (tick && brk_hit) begin
                    nxt_state = ST_BRK;
                end
            end
            ST_STEP: begin
                nxt_state = ST_HALT;
            end
            ST_BRK: begin
                if (mode == MODE_AUTO && run_rise) begin
                    nxt_state = ST_RUN;
                end else if (mode == MODE_STEP && step_rise) begin
                    nxt_state = ST_STEP;
                end
            end
            default: begin
                nxt_state = ST_HALT;
            end
        endcase
    end

    // Leaving BRK fires immediately so the processor moves off the breakpoint.
    always_comb begin
        cpu_en_nxt = 1'b0;
        case (cur_state)
            ST_HALT: cpu_en_nxt = (mode == MODE_STEP) && step_rise;
            ST_RUN:  cpu_en_nxt = (mode == MODE_AUTO) && !run_rise && tick && !brk_hit;
            ST_STEP: cpu_en_nxt = 1'b0;
            ST_BRK:  cpu_en_nxt = ((mode == MODE_AUTO) && run_rise) ||
                                  ((mode == MODE_STEP) && step_rise);
            default: cpu_en_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_en <= 1'b0;
            halted <= 1'b1;
        end else begin
            cpu_en <= cpu_en_nxt;
            halted <= is_halted(nxt_state);
        end
    end

    // Counter only advances while staying in RUN, so every entry restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (cur_state == ST_RUN && nxt_state == ST_RUN) begin
            tick_cnt <= tick ? '0 : tick_cnt + DIV_W'(1);
        end else begin
            tick_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_cnt <= '0;
        end else if (cpu_en) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    assign state = cur_state;

endmodule
